// File: rtl/nn_inference_ctrl.sv
// Inference sequencer: captures a streamed binary image, then walks an external
// single-MAC datapath over every pixel for each output neuron and keeps the arg-max.
module nn_inference_ctrl #(
  parameter int CHUNK_W     = 7,
  parameter int NUM_CHUNKS  = 28,
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_en,
  input  logic [CHUNK_W-1:0]      data_in,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic [7:0]              pix_idx,
  output logic [3:0]              neuron_idx,
  output logic                    pixel_bit,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic                    image_ready,
  output logic                    busy,
  output logic [3:0]              class_out,
  output logic                    done
);

  localparam int IMG_W = CHUNK_W * NUM_CHUNKS;
  localparam logic [7:0] LAST_PIX   = 8'(IMG_W - 1);
  localparam logic [4:0] LAST_CHUNK = 5'(NUM_CHUNKS - 1);
  localparam logic [3:0] LAST_NEUR  = 4'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLR, MAC, DRAIN, CMP, DONE} state_t;

  state_t                  state;
  logic [IMG_W-1:0]        image;
  logic [4:0]              chunk_cnt;
  logic [7:0]              chunk_base;
  logic signed [ACC_W-1:0] best_score;
  logic [3:0]              best_idx;
  logic                    take_new;
  logic [3:0]              win_idx;

  // Strict signed compare: equal scores never displace the earlier (lower) neuron.
  function automatic logic beats(input logic signed [ACC_W-1:0] cand,
                                 input logic signed [ACC_W-1:0] best);
    return cand > best;
  endfunction

  assign chunk_base = 8'(chunk_cnt) * 8'(CHUNK_W);
  assign pixel_bit  = (pix_idx < 8'(IMG_W)) ? image[pix_idx] : 1'b0;
  assign take_new   = (neuron_idx == 4'd0) || beats(acc_in, best_score);
  assign win_idx    = take_new ? neuron_idx : best_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      image       <= '0;
      chunk_cnt   <= '0;
      best_score  <= '0;
      best_idx    <= '0;
      pix_idx     <= '0;
      neuron_idx  <= '0;
      mac_clr     <= 1'b0;
      mac_en      <= 1'b0;
      image_ready <= 1'b0;
      busy        <= 1'b0;
      class_out   <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          image_ready <= 1'b0;
          done        <= 1'b0;
          if (load_en) begin
            image[CHUNK_W-1:0] <= data_in;
            chunk_cnt          <= 5'd1;
            busy               <= 1'b1;
            state              <= LOAD;
          end
        end
        LOAD: begin
          if (load_en) begin
            image[chunk_base +: CHUNK_W] <= data_in;
            if (chunk_cnt == LAST_CHUNK) begin
              chunk_cnt   <= '0;
              image_ready <= 1'b1;
              neuron_idx  <= '0;
              pix_idx     <= '0;
              mac_clr     <= 1'b1;
              state       <= CLR;
            end else begin
              chunk_cnt <= chunk_cnt + 5'd1;
            end
          end else begin
            // Aborted load: partial image stays in the register but is never used.
            chunk_cnt <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        CLR: begin
          mac_clr <= 1'b0;
          mac_en  <= 1'b1;
          pix_idx <= '0;
          state   <= MAC;
        end
        MAC: begin
          if (pix_idx == LAST_PIX) begin
            mac_en  <= 1'b0;
            pix_idx <= '0;
            state   <= DRAIN;
          end else begin
            pix_idx <= pix_idx + 8'd1;
          end
        end
        DRAIN: begin
          // Datapath accumulator is registered; give the last product a cycle to land.
          state <= CMP;
        end
        CMP: begin
          if (take_new) begin
            best_score <= acc_in;
            best_idx   <= neuron_idx;
          end
          if (neuron_idx == LAST_NEUR) begin
            class_out <= win_idx;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            neuron_idx <= neuron_idx + 4'd1;
            mac_clr    <= 1'b1;
            state      <= CLR;
          end
        end
        DONE: begin
          if (load_en) begin
            done               <= 1'b0;
            image_ready        <= 1'b0;
            image[CHUNK_W-1:0] <= data_in;
            chunk_cnt          <= 5'd1;
            busy               <= 1'b1;
            state              <= LOAD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_inference_ctrl.sv
// Directed bench for nn_inference_ctrl with a behavioural MAC or forced accumulator values.
module tb_nn_inference_ctrl;

  logic              clk;
  logic              rst;
  logic              load_en;
  logic [6:0]        data_in;
  logic signed [15:0] acc_in;
  logic [7:0]        pix_idx;
  logic [3:0]        neuron_idx;
  logic              pixel_bit;
  logic              mac_clr;
  logic              mac_en;
  logic              image_ready;
  logic              busy;
  logic [3:0]        class_out;
  logic              done;

  nn_inference_ctrl dut (
    .clk(clk), .rst(rst), .load_en(load_en), .data_in(data_in), .acc_in(acc_in),
    .pix_idx(pix_idx), .neuron_idx(neuron_idx), .pixel_bit(pixel_bit),
    .mac_clr(mac_clr), .mac_en(mac_en), .image_ready(image_ready), .busy(busy),
    .class_out(class_out), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0]         chunks [0:27];
  logic [195:0]       exp_img;
  logic signed [15:0] forced [0:9];
  logic signed [15:0] acc_model;
  bit                 force_mode;

  int n_clr = 0;
  int n_en = 0;
  int n_both = 0;
  int n_pixbad = 0;

  function automatic int wgt(input int n, input int p);
    return n * 3 - (p % 5);
  endfunction

  // Behavioural MAC with a registered accumulator, as the real datapath has.
  always @(posedge clk) begin
    if (mac_clr) acc_model <= 16'sd0;
    else if (mac_en && pixel_bit)
      acc_model <= acc_model + 16'(wgt(int'(neuron_idx), int'(pix_idx)));
    if (mac_clr) n_clr <= n_clr + 1;
    if (mac_en) n_en <= n_en + 1;
    if (mac_clr && mac_en) n_both <= n_both + 1;
    if (mac_en && (pixel_bit !== exp_img[pix_idx])) n_pixbad <= n_pixbad + 1;
  end

  assign acc_in = force_mode ? forced[neuron_idx] : acc_model;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_alt(input logic [6:0] a, input logic [6:0] b);
    for (int i = 0; i < 28; i++) chunks[i] = (i % 2 == 0) ? a : b;
  endtask

  task automatic load_img(input int n);
    for (int i = 0; i < n; i++) begin
      load_en = 1'b1;
      data_in = chunks[i];
      exp_img[i*7 +: 7] = chunks[i];
      tick();
    end
    load_en = 1'b0;
  endtask

  // Waits for done after the chunk-27 edge; checks latency and per-image MAC strobes.
  task automatic run_infer(input string tag, input bit toggle, input int hold_cls,
                           input logic [3:0] exp_cls);
    int lat;
    int clr0;
    int en0;
    lat = 0;
    clr0 = n_clr;
    en0 = n_en;
    while (!done && lat < 3000) begin
      if (toggle) load_en = lat[2];
      tick();
      lat++;
      if (lat == 1000 && hold_cls >= 0) chk({tag, "_class_held"}, class_out, hold_cls);
    end
    load_en = 1'b0;
    chk({tag, "_latency"}, lat, 1990);
    chk({tag, "_class"}, class_out, exp_cls);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_image_ready"}, image_ready, 1);
    chk({tag, "_mac_clr_pulses"}, n_clr - clr0, 10);
    chk({tag, "_mac_en_cycles"}, n_en - en0, 1960);
  endtask

  initial begin
    int g;
    int c0;
    int e0;
    rst = 1'b1;
    load_en = 1'b0;
    data_in = '0;
    force_mode = 1'b0;
    exp_img = '0;
    acc_model = '0;
    for (int i = 0; i < 10; i++) forced[i] = '0;
    tick();
    tick();

    chk("rst_pix_idx", pix_idx, 0);
    chk("rst_neuron_idx", neuron_idx, 0);
    chk("rst_pixel_bit", pixel_bit, 0);
    chk("rst_mac_clr", mac_clr, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_image_ready", image_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_class_out", class_out, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Alternating full/empty chunks; weights rise with neuron index, so neuron 9 wins.
    fill_alt(7'h7F, 7'h00);
    load_img(1);
    chk("alt_busy_loading", busy, 1);
    chk("alt_ready_loading", image_ready, 0);
    for (int i = 1; i < 28; i++) begin
      load_en = 1'b1;
      data_in = chunks[i];
      exp_img[i*7 +: 7] = chunks[i];
      tick();
    end
    load_en = 1'b0;
    chk("alt_ready_at_clr", image_ready, 1);
    chk("alt_mac_clr_first", mac_clr, 1);
    chk("alt_pix_idx_clr", pix_idx, 0);
    run_infer("alt", 1'b0, -1, 4'd9);
    chk("alt_done", done, 1);

    // Empty image: every neuron scores 0, ties keep neuron 0.
    fill_alt(7'h00, 7'h00);
    load_img(28);
    run_infer("zero", 1'b0, -1, 4'd0);

    // All-negative scores with ties at -1: earliest -1 (neuron 4) must win.
    force_mode = 1'b1;
    forced[0] = -16'sd5;  forced[1] = -16'sd2; forced[2] = -16'sd2; forced[3] = -16'sd9;
    forced[4] = -16'sd1;  forced[5] = -16'sd1; forced[6] = -16'sd30; forced[7] = -16'sd1;
    forced[8] = -16'sd3;  forced[9] = -16'sd4;
    fill_alt(7'h55, 7'h2A);
    load_img(28);
    run_infer("neg_ties", 1'b0, -1, 4'd4);

    // Mixed signs: unsigned compare would pick -1 at neuron 7; signed max is 5 at neuron 0.
    forced[0] = 16'sd5;   forced[1] = -16'sd3; forced[2] = 16'sd2;  forced[3] = -16'sd100;
    forced[4] = 16'sd4;   forced[5] = 16'sd1;  forced[6] = 16'sd0;  forced[7] = -16'sd1;
    forced[8] = 16'sd3;   forced[9] = -16'sd32768;
    load_img(28);
    run_infer("signed", 1'b0, -1, 4'd0);
    force_mode = 1'b0;

    // Aborted load after 12 chunks.
    c0 = n_clr;
    e0 = n_en;
    fill_alt(7'h55, 7'h55);
    load_img(12);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_busy", busy, 0);
    chk("abort_image_ready", image_ready, 0);
    chk("abort_done", done, 0);
    chk("abort_no_mac_clr", n_clr - c0, 0);
    chk("abort_no_mac_en", n_en - e0, 0);
    load_img(28);
    run_infer("after_abort", 1'b0, -1, 4'd9);

    // Class 7, then a back-to-back image straight out of DONE.
    force_mode = 1'b1;
    forced[0] = 16'sd0;  forced[1] = 16'sd1;  forced[2] = 16'sd2;  forced[3] = 16'sd3;
    forced[4] = 16'sd4;  forced[5] = 16'sd5;  forced[6] = 16'sd6;  forced[7] = 16'sd50;
    forced[8] = -16'sd7; forced[9] = 16'sd7;
    load_img(28);
    run_infer("seven", 1'b0, -1, 4'd7);
    force_mode = 1'b0;
    fill_alt(7'h7F, 7'h7F);
    load_img(1);
    chk("b2b_done_falls", done, 0);
    chk("b2b_class_kept", class_out, 7);
    chk("b2b_ready_cleared", image_ready, 0);
    chk("b2b_busy", busy, 1);
    for (int i = 1; i < 28; i++) begin
      load_en = 1'b1;
      data_in = chunks[i];
      exp_img[i*7 +: 7] = chunks[i];
      tick();
    end
    load_en = 1'b0;
    run_infer("b2b", 1'b0, 7, 4'd9);

    // load_en toggling throughout the inference must be ignored.
    fill_alt(7'h2A, 7'h15);
    load_img(28);
    run_infer("toggle", 1'b1, -1, 4'd9);

    // Asynchronous reset in the middle of neuron 4.
    fill_alt(7'h7F, 7'h00);
    load_img(28);
    g = 0;
    while (!(neuron_idx == 4'd4 && pix_idx == 8'd100) && g < 3000) begin
      tick();
      g++;
    end
    chk("mid_reached", (g < 3000) ? 1 : 0, 1);
    chk("mid_mac_en", mac_en, 1);
    rst = 1'b1;
    #1;
    chk("midrst_pix_idx", pix_idx, 0);
    chk("midrst_neuron_idx", neuron_idx, 0);
    chk("midrst_pixel_bit", pixel_bit, 0);
    chk("midrst_mac_en", mac_en, 0);
    chk("midrst_mac_clr", mac_clr, 0);
    chk("midrst_image_ready", image_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_class", class_out, 0);
    chk("midrst_done", done, 0);
    tick();
    rst = 1'b0;
    tick();
    fill_alt(7'h00, 7'h7F);
    load_img(28);
    run_infer("post_rst", 1'b0, -1, 4'd9);

    chk("pixel_bit_stream", n_pixbad, 0);
    chk("clr_en_overlap", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
